xadc_scan_avg: RTL and testbench

XADC_SCAN_AVG -- requirements
Module: xadc_scan_avg

---
 rtl/xadc_pkg.sv | 28 ++
 rtl/xadc_avg_acc.sv | 52 +++++
 rtl/xadc_scan_avg.sv | 143 ++++++++++++++
 tb/tb_xadc_scan_avg.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC channel scanner/averager.
package xadc_pkg;

    // Width of one XADC conversion result.
    localparam int ADC_W = 12;

    // DRP status-register addresses of the common XADC channels.
    localparam logic [6:0] ADDR_TEMP   = 7'h00;
    localparam logic [6:0] ADDR_VCCINT = 7'h01;
    localparam logic [6:0] ADDR_VCCAUX = 7'h02;
    localparam logic [6:0] ADDR_VPVN   = 7'h03;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOC,
        S_WAIT_EOC,
        S_READ,
        S_WAIT_RDY,
        S_ACC,
        S_OUT
    } xadc_state_t;

    // Channel index width; a single channel still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xadc_avg_acc.sv
// Per-channel sample register, accumulator, sample counter and shift-divide.
module xadc_avg_acc
    import xadc_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             smp_ld,
    input  logic [ADC_W-1:0] smp_in,
    input  logic             add,
    output logic             last,
    output logic [ADC_W-1:0] avg_nxt
);

    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ADC_W-1:0] smp_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt_q;

    // Hold the most recent DRP code until it is accumulated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         smp_q <= '0;
        else if (smp_ld) smp_q <= smp_in;
    end

    // Running sum and sample count; cleared when a channel completes or is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (add) begin
            acc_q <= acc_sum;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // The sum including the pending sample; on the last add this is the full
    // 2^AVG_LOG2-sample total, so the top ADC_W bits are the truncated mean.
    assign acc_sum = acc_q + ACC_W'(smp_q);
    assign last    = (cnt_q == CNT_LAST);
    assign avg_nxt = acc_sum[ACC_W-1 -: ADC_W];

endmodule

// File: rtl/xadc_scan_avg.sv
// XADC round-robin channel scanner with per-channel boxcar averaging.
// Optional watchdog on the EOC/DRP-ready waits: define XADC_SCAN_TIMEOUT_EN.
module xadc_scan_avg
    import xadc_pkg::*;
#(
    parameter int                  NUM_CH      = 2,
    parameter logic [7*NUM_CH-1:0] CH_ADDR     = {7'h03, 7'h00},
    parameter int                  AVG_LOG2    = 2,
    parameter int                  TIMEOUT_CYC = 1024
) (
    input  logic                      AdcClk,
    input  logic                      AdcRst,
    input  logic                      Enable,
    output logic                      AdcSoc,
    input  logic                      AdcEoc,
    output logic [6:0]                DrpAddr,
    output logic                      DrpEn,
    input  logic [15:0]               DrpDo,
    input  logic                      DrpRdy,
    output logic [ADC_W-1:0]          SmpData,
    output logic [idx_w(NUM_CH)-1:0]  SmpChan,
    output logic                      SmpValid,
    output logic                      Busy,
    output logic                      Error
);

    localparam int CH_W = idx_w(NUM_CH);
    localparam logic [CH_W-1:0] IDX_LAST = CH_W'(NUM_CH - 1);

    if (NUM_CH < 1 || NUM_CH > 8 || AVG_LOG2 < 0 || AVG_LOG2 > 6 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("xadc_scan_avg: parameter out of range");
    end

    xadc_state_t      state_q, state_d;
    logic [CH_W-1:0]  idx_q;
    logic [6:0]       ch_addr;
    logic             timeout;
    logic             chan_done;
    logic             acc_last;
    logic [ADC_W-1:0] avg_nxt;

    // A channel finishes either normally (OUT) or by being abandoned on timeout.
    assign chan_done = (state_q == S_OUT) || timeout;

    xadc_avg_acc #(.AVG_LOG2(AVG_LOG2)) u_acc (
        .clk     (AdcClk),
        .rst     (AdcRst),
        .clr     (chan_done),
        .smp_ld  ((state_q == S_WAIT_RDY) && DrpRdy),
        .smp_in  (DrpDo[15:4]),
        .add     (state_q == S_ACC),
        .last    (acc_last),
        .avg_nxt (avg_nxt)
    );

`ifdef XADC_SCAN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            err_q;
    logic            waiting;
    logic            wait_evt;

    assign waiting  = (state_q == S_WAIT_EOC) || (state_q == S_WAIT_RDY);
    assign wait_evt = ((state_q == S_WAIT_EOC) && AdcEoc) || ((state_q == S_WAIT_RDY) && DrpRdy);
    // An arriving event in the final cycle still wins over the watchdog.
    assign timeout  = waiting && !wait_evt && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
    assign Error    = err_q;

    // Count cycles spent in a wait state; latch a sticky error when the limit is hit.
    always_ff @(posedge AdcClk or posedge AdcRst) begin
        if (AdcRst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (!waiting || wait_evt || timeout) to_cnt_q <= '0;
            else                                 to_cnt_q <= to_cnt_q + TO_W'(1);
            if (timeout) err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign Error   = 1'b0;
`endif

    // State register.
    always_ff @(posedge AdcClk or posedge AdcRst) begin
        if (AdcRst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; stray EOC/RDY pulses only matter in their own wait state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (Enable) state_d = S_SOC;
            S_SOC:      state_d = S_WAIT_EOC;
            S_WAIT_EOC: if (AdcEoc)       state_d = S_READ;
                        else if (timeout) state_d = Enable ? S_SOC : S_IDLE;
            S_READ:     state_d = S_WAIT_RDY;
            S_WAIT_RDY: if (DrpRdy)       state_d = S_ACC;
                        else if (timeout) state_d = Enable ? S_SOC : S_IDLE;
            S_ACC:      state_d = acc_last ? S_OUT : S_SOC;
            S_OUT:      state_d = Enable ? S_SOC : S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Address of the channel currently being scanned.
    always_comb begin
        ch_addr = 7'h00;
        for (int i = 0; i < NUM_CH; i++)
            if (idx_q == CH_W'(i)) ch_addr = CH_ADDR[7*i +: 7];
    end

    // Moore outputs decoded from state.
    always_comb begin
        AdcSoc   = (state_q == S_SOC);
        DrpEn    = (state_q == S_READ);
        SmpValid = (state_q == S_OUT);
        Busy     = (state_q != S_IDLE);
        DrpAddr  = (state_q == S_IDLE) ? 7'h00 : ch_addr;
    end

    // Result registers load on the edge into OUT; channel index advances as a channel ends.
    always_ff @(posedge AdcClk or posedge AdcRst) begin
        if (AdcRst) begin
            idx_q   <= '0;
            SmpData <= '1;
            SmpChan <= '0;
        end else begin
            if ((state_q == S_ACC) && acc_last) begin
                SmpData <= avg_nxt;
                SmpChan <= idx_q;
            end
            if (chan_done) begin
                if (!Enable || idx_q == IDX_LAST) idx_q <= '0;
                else                              idx_q <= idx_q + CH_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_xadc_scan_avg.sv
// Self-checking bench: behavioural XADC/DRP model plus a result scoreboard.
module tb_xadc_scan_avg;
    import xadc_pkg::*;

    localparam int          NUM_CH      = 2;
    localparam int          AVG_LOG2    = 2;
    localparam int          TIMEOUT_CYC = 16;
    localparam logic [13:0] CH_ADDR     = {ADDR_TEMP, ADDR_VPVN};  // ch0 = 03, ch1 = 00

    logic        AdcClk = 1'b0;
    logic        AdcRst, Enable, AdcSoc, AdcEoc, DrpEn, DrpRdy, SmpValid, Busy, Error;
    logic [6:0]  DrpAddr;
    logic [15:0] DrpDo;
    logic [11:0] SmpData;
    logic [0:0]  SmpChan;

    always #5 AdcClk = ~AdcClk;

    xadc_scan_avg #(
        .NUM_CH(NUM_CH), .CH_ADDR(CH_ADDR), .AVG_LOG2(AVG_LOG2), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .AdcClk(AdcClk), .AdcRst(AdcRst), .Enable(Enable), .AdcSoc(AdcSoc), .AdcEoc(AdcEoc),
        .DrpAddr(DrpAddr), .DrpEn(DrpEn), .DrpDo(DrpDo), .DrpRdy(DrpRdy),
        .SmpData(SmpData), .SmpChan(SmpChan), .SmpValid(SmpValid), .Busy(Busy), .Error(Error)
    );

    typedef struct packed { logic [0:0] chan; logic [11:0] data; } exp_t;
    typedef struct packed { logic [47:0] s; logic [11:0] avg; } vec_t;

    exp_t        exp_q[$];
    logic [11:0] smp_q[$];
    logic [6:0]  addr_q[$];
    vec_t        vt[6];

    int tests = 0, fails = 0;
    int eoc_tmr = 0, rdy_tmr = 0, rdy_age = 100, n_valid = 0, n_drpen = 0;
    int eoc_dly = 3, rdy_dly = 2;
    bit withhold = 0, noise = 0, stop_when_empty = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample at negedge, run scoreboard, then drive the XADC model.
    task automatic step();
        exp_t e;
        logic [11:0] s;
        @(negedge AdcClk);
        AdcEoc = 1'b0;
        DrpRdy = 1'b0;
        rdy_age++;
        if (SmpValid) begin
            n_valid++;
            if (exp_q.size() == 0) check("unexpected SmpValid", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("SmpData", 32'(SmpData), 32'(e.data));
                check("SmpChan", 32'(SmpChan), 32'(e.chan));
                check("rdy-to-valid latency", 32'(rdy_age), 32'd2);
                if (stop_when_empty && exp_q.size() == 0) Enable = 1'b0;
            end
        end
        if (eoc_tmr > 0) begin
            eoc_tmr--;
            if (eoc_tmr == 0) begin
                AdcEoc = 1'b1;
                if (noise) begin DrpRdy = 1'b1; DrpDo = 16'hFFF0; end
            end
        end
        if (rdy_tmr > 0) begin
            rdy_tmr--;
            if (rdy_tmr == 0) begin
                s = 12'h000;
                if (smp_q.size() > 0) s = smp_q.pop_front();
                DrpDo   = {s, 4'h5};
                DrpRdy  = 1'b1;
                rdy_age = 0;
                if (noise) AdcEoc = 1'b1;
            end
        end
        if (AdcSoc && !withhold) eoc_tmr = eoc_dly;
        if (DrpEn) begin
            n_drpen++;
            if (addr_q.size() == 0) check("unexpected DrpEn", 32'd1, 32'd0);
            else check("DrpAddr on DrpEn", 32'(DrpAddr), 32'(addr_q.pop_front()));
            rdy_tmr = rdy_dly;
        end
    endtask

    task automatic run_until_empty(input string name, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin step(); n++; end
        if (exp_q.size() > 0) check({name, " result timeout"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic push_chan(input logic [47:0] s, input logic [0:0] ch, input logic [11:0] avg);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            smp_q.push_back(s[47-12*k -: 12]);
            addr_q.push_back(ch == 1'b0 ? ADDR_VPVN : ADDR_TEMP);
        end
        e.chan = ch;
        e.data = avg;
        exp_q.push_back(e);
    endtask

    task automatic check_idle(input string name);
        repeat (3) step();
        check({name, " Busy"}, 32'(Busy), 32'd0);
        check({name, " DrpAddr idle"}, 32'(DrpAddr), 32'd0);
        check({name, " reads consumed"}, 32'(addr_q.size()), 32'd0);
    endtask

    initial begin
        int base, n;
        AdcRst = 1'b1; Enable = 1'b0; AdcEoc = 1'b0; DrpRdy = 1'b0; DrpDo = 16'h0;

        // Reset state
        repeat (3) @(negedge AdcClk);
        check("rst AdcSoc", 32'(AdcSoc), 32'd0);
        check("rst DrpEn", 32'(DrpEn), 32'd0);
        check("rst SmpValid", 32'(SmpValid), 32'd0);
        check("rst SmpData", 32'(SmpData), 32'hFFF);
        check("rst SmpChan", 32'(SmpChan), 32'd0);
        check("rst Busy", 32'(Busy), 32'd0);
        check("rst Error", 32'(Error), 32'd0);
        check("rst DrpAddr", 32'(DrpAddr), 32'd0);
        AdcRst = 1'b0;
        step();
        check("idle after release", 32'(Busy), 32'd0);

        // Table: continuous scan, channels alternate 0,1,0,...
        vt[0] = '{48'hABC_ABC_ABC_ABC, 12'hABC};
        vt[1] = '{48'h001_002_003_003, 12'h002};
        vt[2] = '{48'hFFF_FFF_FFF_FFF, 12'hFFF};
        vt[3] = '{48'h000_000_000_003, 12'h000};
        vt[4] = '{48'hFFF_FFF_FFF_FFE, 12'hFFE};
        vt[5] = '{48'h100_200_300_400, 12'h280};
        for (int v = 0; v < 6; v++) push_chan(vt[v].s, 1'(v % 2), vt[v].avg);
        stop_when_empty = 1'b1;
        Enable = 1'b1;
        run_until_empty("table", 2000);
        check_idle("table");
        repeat (5) step();
        check("SmpData hold", 32'(SmpData), 32'h280);
        check("SmpChan hold", 32'(SmpChan), 32'd1);

        // Enable dropped after the 2nd sample: channel 0 still completes, once.
        stop_when_empty = 1'b0;
        base = n_valid;
        push_chan(48'h010_020_030_041, 1'b0, 12'h028);
        Enable = 1'b1;
        n = 0;
        while (smp_q.size() > 2 && n < 200) begin step(); n++; end
        check("enable-drop reached 2nd sample", 32'(smp_q.size()), 32'd2);
        Enable = 1'b0;
        run_until_empty("enable-drop", 200);
        check_idle("enable-drop");
        check("enable-drop result count", 32'(n_valid - base), 32'd1);

        // Stray EOC/RDY pulses in the wrong states; index restarted at 0.
        noise = 1'b1;
        stop_when_empty = 1'b1;
        push_chan(48'h123_456_789_ABC, 1'b0, 12'h5EF);
        Enable = 1'b1;
        run_until_empty("noise", 400);
        noise = 1'b0;
        check_idle("noise");

        // Reset while waiting for the 2nd DRP read; late DrpRdy must be ignored.
        rdy_dly = 6;
        base = n_drpen;
        smp_q.push_back(12'h7FF); smp_q.push_back(12'h7FF);
        addr_q.push_back(ADDR_VPVN); addr_q.push_back(ADDR_VPVN);
        stop_when_empty = 1'b0;
        Enable = 1'b1;
        n = 0;
        while (n_drpen < base + 2 && n < 200) begin step(); n++; end
        check("reset test reached 2nd read", 32'(n_drpen - base), 32'd2);
        step(); step();
        #1 AdcRst = 1'b1;
        #1;
        check("async rst Busy", 32'(Busy), 32'd0);
        check("async rst DrpEn", 32'(DrpEn), 32'd0);
        check("async rst AdcSoc", 32'(AdcSoc), 32'd0);
        check("async rst SmpData", 32'(SmpData), 32'hFFF);
        check("async rst SmpChan", 32'(SmpChan), 32'd0);
        check("async rst DrpAddr", 32'(DrpAddr), 32'd0);
        Enable = 1'b0;
        base = n_valid;
        step();
        AdcRst = 1'b0;
        repeat (8) step();
        check("late DrpRdy ignored Busy", 32'(Busy), 32'd0);
        check("late DrpRdy no result", 32'(n_valid - base), 32'd0);
        smp_q.delete();
        rdy_dly = 2;
        stop_when_empty = 1'b1;
        push_chan(48'h400_400_400_400, 1'b0, 12'h400);
        Enable = 1'b1;
        run_until_empty("post-reset", 400);
        check_idle("post-reset");

        // Withheld EOC.
        withhold = 1'b1;
        base = n_valid;
        Enable = 1'b1;
        n = 0;
        while (!AdcSoc && n < 20) begin step(); n++; end
        check("withheld SOC seen", 32'(AdcSoc), 32'd1);
`ifdef XADC_SCAN_TIMEOUT_EN
        n = 0;
        while (!Error && n < 40) begin step(); n++; end
        check("timeout Error", 32'(Error), 32'd1);
        check("timeout cycles SOC->Error", 32'(n), 32'd17);
        check("timeout no result", 32'(n_valid - base), 32'd0);
        withhold = 1'b0;
        eoc_tmr = eoc_dly;
        push_chan(48'h0FF_0FF_0FF_0FF, 1'b1, 12'h0FF);
`else
        repeat (40) step();
        check("unbounded wait Busy", 32'(Busy), 32'd1);
        check("no watchdog Error", 32'(Error), 32'd0);
        check("no read while waiting", 32'(n_valid - base), 32'd0);
        withhold = 1'b0;
        eoc_tmr = 1;
        push_chan(48'h0FF_0FF_0FF_0FF, 1'b0, 12'h0FF);
`endif
        run_until_empty("withheld-eoc", 400);
        check_idle("withheld-eoc");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
